// File: rtl/rr_buffer_arbiter.sv
// Round-robin drain of NUM_PORTS one-cycle-latency read buffers into a 2-entry output queue.
// A grant issues a consume strobe; the returned word is captured one cycle later with its source index.
module rr_buffer_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned WIDTH     = 64,
  localparam int unsigned SRC_W    = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_PORTS-1:0]       buf_empty,
  input  logic [NUM_PORTS*WIDTH-1:0] buf_data,
  output logic [NUM_PORTS-1:0]       buf_consume,
  output logic [WIDTH-1:0]           out_data,
  output logic [SRC_W-1:0]           out_src,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  logic [1:0]       r_occ;
  logic             r_inflight;
  logic [SRC_W-1:0] r_infl_src;
  logic [SRC_W-1:0] r_last;
  logic [WIDTH-1:0] r_q_data [2];
  logic [SRC_W-1:0] r_q_src  [2];

  logic             w_found;
  logic [SRC_W-1:0] w_pick;
  logic [SRC_W-1:0] w_cand;
  logic             w_pop;
  logic [1:0]       w_load;
  logic             w_grant;
  logic             w_wr_pos;
  logic [WIDTH-1:0] w_cap_data;
  logic [NUM_PORTS-1:0] w_consume;

  // Search starts one past the last granted port and wraps.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      w_cand = SRC_W'((32'(r_last) + i) % NUM_PORTS);
      if (!w_found && !buf_empty[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_pop   = out_valid && out_ready;
  assign w_load  = r_occ + 2'(r_inflight);
  // Queue slots are reserved at grant time, counting the word still in flight.
  assign w_grant = !rst && en && w_found && ((w_load < 2'd2) || w_pop);

  always_comb begin
    w_consume = '0;
    if (w_grant) w_consume[w_pick] = 1'b1;
  end

  assign buf_consume = w_consume;
  assign w_cap_data  = buf_data[32'(r_infl_src) * WIDTH +: WIDTH];
  // Tail slot after any head pop this cycle.
  assign w_wr_pos    = w_pop ? (r_occ == 2'd2) : (r_occ == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ       <= '0;
      r_inflight  <= 1'b0;
      r_infl_src  <= '0;
      r_last      <= SRC_W'(NUM_PORTS - 1);
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_src[0]  <= '0;
      r_q_src[1]  <= '0;
    end else begin
      r_inflight <= w_grant;
      if (w_grant) begin
        r_last     <= w_pick;
        r_infl_src <= w_pick;
      end
      if (w_pop) begin
        r_q_data[0] <= r_q_data[1];
        r_q_src[0]  <= r_q_src[1];
      end
      if (r_inflight) begin
        r_q_data[w_wr_pos] <= w_cap_data;
        r_q_src[w_wr_pos]  <= r_infl_src;
      end
      r_occ <= r_occ + 2'(r_inflight) - 2'(w_pop);
    end
  end

  assign out_valid = (r_occ != 2'd0);
  assign out_data  = r_q_data[0];
  assign out_src   = r_q_src[0];
  assign busy      = r_inflight || (r_occ != 2'd0);

endmodule

// File: tb/tb_rr_buffer_arbiter.sv
// Directed bench for rr_buffer_arbiter: behavioural 1-cycle-latency buffers per port and
// hand-computed per-cycle expectations for grants, queue head and busy.
module tb_rr_buffer_arbiter;
  localparam int NP = 4;
  localparam int W  = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            out_ready = 1'b0;
  logic [NP-1:0]   buf_empty;
  logic [NP*W-1:0] buf_data;
  logic [NP-1:0]   buf_consume;
  logic [W-1:0]    out_data;
  logic [1:0]      out_src;
  logic            out_valid;
  logic            busy;

  int lvl [NP];
  int ptr [NP];
  int n_vec = 0;
  int n_err = 0;

  rr_buffer_arbiter #(.NUM_PORTS(NP), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .buf_empty   (buf_empty),
    .buf_data    (buf_data),
    .buf_consume (buf_consume),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word(int p, int k);
    return 64'hC0DE_0000_0000_0000 | (64'(p) << 16) | 64'(k);
  endfunction

  always_comb begin
    for (int p = 0; p < NP; p++) buf_empty[p] = (ptr[p] >= lvl[p]);
  end

  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rst) begin
        ptr[p] <= 0;
      end else if (buf_consume[p]) begin
        buf_data[p*W +: W] <= word(p, ptr[p]);
        ptr[p] <= ptr[p] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(string tag, logic [3:0] cons, logic v, int src, int k);
    chk({tag, "_cons"}, 64'(buf_consume), 64'(cons));
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    if (v) begin
      chk({tag, "_src"}, 64'(out_src), 64'(src));
      chk({tag, "_data"}, out_data, word(src, k));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_cons", 64'(buf_consume), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      lvl[p] = 2;
      ptr[p] = 0;
    end

    // Reset with ports non-empty and en high: nothing may be granted or shown.
    en = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    #1;
    chk("init_cons", 64'(buf_consume), 64'd0);
    chk("init_valid", 64'(out_valid), 64'd0);
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_data", out_data, 64'd0);
    chk("init_src", 64'(out_src), 64'd0);

    // All ports busy, sink always ready: grants 0,1,2,3,0,... and one word per cycle.
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int c = 0; c <= 10; c++) begin
      expect_out($sformatf("s1c%0d", c), (c < 8) ? 4'(1 << (c % 4)) : 4'd0,
                 (c >= 2 && c <= 9), (c - 2) % 4, (c - 2) / 4);
      chk($sformatf("s1c%0d_busy", c), 64'(busy), 64'(c >= 1 && c <= 9));
      tick();
      #1;
    end

    // Only port 2 holds three words.
    lvl[0] = 0; lvl[1] = 0; lvl[2] = 3; lvl[3] = 0;
    do_reset();
    #1;
    for (int c = 0; c <= 5; c++) begin
      expect_out($sformatf("s2c%0d", c), (c < 3) ? 4'd4 : 4'd0, (c >= 2 && c <= 4), 2, c - 2);
      tick();
      #1;
    end

    // Back-pressure: two grants fill the queue, then release and stream.
    for (int p = 0; p < NP; p++) lvl[p] = 3;
    do_reset();
    out_ready = 1'b0;
    #1;
    expect_out("s3c0", 4'd1, 1'b0, 0, 0); tick(); #1;
    expect_out("s3c1", 4'd2, 1'b0, 0, 0); tick(); #1;
    expect_out("s3c2", 4'd0, 1'b1, 0, 0); tick(); #1;
    expect_out("s3c3", 4'd0, 1'b1, 0, 0);
    chk("s3c3_busy", 64'(busy), 64'd1);
    tick(); #1;
    expect_out("s3c4", 4'd0, 1'b1, 0, 0);
    tick();
    out_ready = 1'b1;
    #1;
    expect_out("s3c5", 4'd4, 1'b1, 0, 0); tick(); #1;
    expect_out("s3c6", 4'd8, 1'b1, 1, 0); tick(); #1;
    expect_out("s3c7", 4'd1, 1'b1, 2, 0); tick(); #1;
    expect_out("s3c8", 4'd2, 1'b1, 3, 0);

    // Reset mid-stream with a word queued and another in flight.
    tick();
    rst = 1'b1;
    lvl[0] = 0;
    lvl[1] = 0;
    #1;
    expect_out("s3c9", 4'd0, 1'b1, 0, 1);
    tick();
    rst = 1'b0;
    #1;
    expect_out("s6c0", 4'd4, 1'b0, 0, 0);
    chk("s6c0_busy", 64'(busy), 64'd0);
    tick(); #1;
    expect_out("s6c1", 4'd8, 1'b0, 0, 0); tick(); #1;
    expect_out("s6c2", 4'd4, 1'b1, 2, 0);

    // en drops right after a grant: the in-flight word still arrives.
    lvl[0] = 0; lvl[1] = 2; lvl[2] = 0; lvl[3] = 0;
    do_reset();
    #1;
    expect_out("s4c0", 4'd2, 1'b0, 0, 0);
    tick();
    en = 1'b0;
    #1;
    expect_out("s4c1", 4'd0, 1'b0, 0, 0);
    chk("s4c1_busy", 64'(busy), 64'd1);
    tick(); #1;
    expect_out("s4c2", 4'd0, 1'b1, 1, 0);
    chk("s4c2_busy", 64'(busy), 64'd1);
    tick(); #1;
    expect_out("s4c3", 4'd0, 1'b0, 0, 0);
    chk("s4c3_busy", 64'(busy), 64'd0);

    // Wrap from last grant 3 with ports 1 and 3 pending.
    lvl[0] = 0; lvl[1] = 0; lvl[2] = 0; lvl[3] = 1;
    en = 1'b1;
    do_reset();
    #1;
    expect_out("s5c0", 4'd8, 1'b0, 0, 0);
    tick();
    lvl[1] = 2;
    lvl[3] = 2;
    #1;
    expect_out("s5c1", 4'd2, 1'b0, 0, 0); tick(); #1;
    expect_out("s5c2", 4'd8, 1'b1, 3, 0); tick(); #1;
    expect_out("s5c3", 4'd2, 1'b1, 1, 0); tick(); #1;
    expect_out("s5c4", 4'd0, 1'b1, 3, 1); tick(); #1;
    expect_out("s5c5", 4'd0, 1'b1, 1, 1); tick(); #1;
    expect_out("s5c6", 4'd0, 1'b0, 0, 0);
    chk("s5c6_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
